// File: rtl/ospi_pkg.sv
`default_nettype none
// ============================================================================
// ospi_pkg : shared types and constants for the OSPI host sequencer
// Rev 1.0  : initial release
// ============================================================================
package ospi_pkg;

    // FSM state encoding, kept as plain constants so legacy code can reuse it
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CMD   = 3'd1;
    localparam state_t ST_ADDR  = 3'd2;
    localparam state_t ST_DUMMY = 3'd3;
    localparam state_t ST_WDATA = 3'd4;
    localparam state_t ST_RDATA = 3'd5;
    localparam state_t ST_GAP   = 3'd6;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    typedef logic [8:0] len_t;

    localparam len_t LEN_MAX = 9'd256;

    function automatic len_t clamp_len(input len_t len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ospi_sclk_gen.sv
`default_nettype none
// ============================================================================
// ospi_sclk_gen : SCLK cell timer (HALF clk low, HALF clk high per cell)
// Rev 1.0       : initial release
// ============================================================================
module ospi_sclk_gen #(
    parameter int HALF = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic hold,
    output logic sclk,
    output logic cell_start,
    output logic cell_end,
    output logic busy
);

    localparam int            CW   = (HALF > 1) ? $clog2(2 * HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(2 * HALF - 1);
    localparam logic [CW-1:0] HI   = CW'(HALF);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          sclk_q, sclk_d;

    always_comb begin
        cell_end   = busy_q && (cnt_q == LAST);
        // a new cell may begin from idle or exactly where the previous one ends
        cell_start = run && !hold && (!busy_q || cell_end);
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        if (cell_start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
        end else if (cell_end) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (busy_q) begin
            cnt_d = cnt_q + 1'b1;
        end
        sclk_d = busy_d && (cnt_d >= HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;
    assign busy = busy_q;

endmodule
`default_nettype wire

// File: rtl/ospi_host_seq.sv
`default_nettype none
// ============================================================================
// ospi_host_seq : OSPI host transfer sequencer (CMD, ADDR, DUMMY, DATA, GAP)
// Option        : OSPI_HOST_TIMEOUT_EN adds err port and write-stall timeout
// Rev 1.0       : initial release
// ============================================================================
module ospi_host_seq
    import ospi_pkg::*;
#(
    parameter int HALF   = 1,
    parameter int DUMMY  = 4,
    parameter int CS_GAP = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_opcode,
    input  logic [7:0] req_addr,
    input  logic [8:0] req_len,
    input  logic       wdata_valid,
    output logic       wdata_ready,
    input  logic [7:0] wdata,
    output logic       rdata_valid,
    output logic [7:0] rdata,
    output logic       done,
    output logic       cs_n,
    output logic       sclk,
    output logic [7:0] dq_out,
    output logic       dq_oe,
    input  logic [7:0] dq_in
`ifdef OSPI_HOST_TIMEOUT_EN
    ,
    output logic       err
`endif
);

    localparam logic [7:0] GAP_LOAD    = 8'((CS_GAP > 1) ? CS_GAP - 1 : 0);
    localparam len_t       DUMMY_CELLS = len_t'(DUMMY);

    state_t     state_q, state_d;
    len_t       cnt_q, cnt_d;
    len_t       len_q, len_d;
    logic [7:0] addr_q, addr_d;
    logic       write_q, write_d;
    logic [7:0] gap_q, gap_d;
    logic       cs_n_q, cs_n_d;
    logic [7:0] dq_out_q, dq_out_d;
    logic       dq_oe_q, dq_oe_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rdata_valid_q, rdata_valid_d;
    logic       done_q, done_d;
    logic       init_q;

    state_t     w_next_state;
    len_t       w_next_cnt;
    logic       w_ready, w_hs, w_run, w_hold, w_want_wdata;
    logic       w_cell_start, w_cell_end, w_busy;
    logic       w_timeout;

    ospi_sclk_gen #(
        .HALF (HALF)
    ) u_sclk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (w_run),
        .hold       (w_hold),
        .sclk       (sclk),
        .cell_start (w_cell_start),
        .cell_end   (w_cell_end),
        .busy       (w_busy)
    );

    // Phase that follows the cell currently in flight
    always_comb begin
        w_next_state = ST_GAP;
        w_next_cnt   = 9'd1;
        case (state_q)
            ST_CMD: w_next_state = ST_ADDR;
            ST_ADDR: begin
                if (len_q == '0) begin
                    w_next_state = ST_GAP;
                end else if (write_q) begin
                    w_next_state = ST_WDATA;
                    w_next_cnt   = len_q;
                end else if (DUMMY > 0) begin
                    w_next_state = ST_DUMMY;
                    w_next_cnt   = DUMMY_CELLS;
                end else begin
                    w_next_state = ST_RDATA;
                    w_next_cnt   = len_q;
                end
            end
            ST_DUMMY: begin
                if (cnt_q > 9'd1) begin
                    w_next_state = ST_DUMMY;
                    w_next_cnt   = cnt_q - 9'd1;
                end else begin
                    w_next_state = ST_RDATA;
                    w_next_cnt   = len_q;
                end
            end
            ST_WDATA, ST_RDATA: begin
                if (cnt_q > 9'd1) begin
                    w_next_state = state_q;
                    w_next_cnt   = cnt_q - 9'd1;
                end
            end
            default: ;
        endcase
    end

    // A write cell is pending either at a cell boundary or while stalled
    assign w_want_wdata = (state_q == ST_WDATA && !w_busy) ||
                          (w_cell_end && w_next_state == ST_WDATA);
    assign w_ready      = init_q && (state_q == ST_IDLE);
    assign w_hs         = req_valid && w_ready;
    assign w_run        = w_hs || (w_cell_end && w_next_state != ST_GAP) ||
                          (state_q == ST_WDATA && !w_busy);
    assign w_hold       = w_want_wdata && !wdata_valid;

`ifdef OSPI_HOST_TIMEOUT_EN
    logic [11:0] stall_q, stall_d;
    logic        err_q, err_d;

    assign w_timeout = w_hold && (stall_q == 12'd4094);

    always_comb begin
        stall_d = w_hold ? stall_q + 12'd1 : 12'd0;
        err_d   = w_timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        addr_d        = addr_q;
        write_d       = write_q;
        gap_d         = gap_q;
        cs_n_d        = cs_n_q;
        dq_out_d      = dq_out_q;
        dq_oe_d       = dq_oe_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_hs) begin
                    state_d  = ST_CMD;
                    cnt_d    = 9'd1;
                    len_d    = clamp_len(req_len);
                    addr_d   = req_addr;
                    write_d  = req_write;
                    cs_n_d   = 1'b0;
                    dq_out_d = req_opcode;
                    dq_oe_d  = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                if (w_cell_end) begin
                    if (state_q == ST_RDATA) begin
                        rdata_d       = dq_in;
                        rdata_valid_d = 1'b1;
                    end
                    if (w_next_state == ST_GAP) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LOAD;
                        cs_n_d  = 1'b1;
                        dq_oe_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = w_next_state;
                        cnt_d   = w_next_cnt;
                    end
                end
                if (w_cell_start) begin
                    case (state_d)
                        ST_ADDR: begin
                            dq_out_d = addr_q;
                            dq_oe_d  = 1'b1;
                        end
                        ST_WDATA: begin
                            dq_out_d = wdata;
                            dq_oe_d  = 1'b1;
                        end
                        default: dq_oe_d = 1'b0;
                    endcase
                end
            end
        endcase
        if (w_timeout) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
            cs_n_d  = 1'b1;
            dq_oe_d = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            len_q         <= '0;
            addr_q        <= '0;
            write_q       <= 1'b0;
            gap_q         <= '0;
            cs_n_q        <= 1'b1;
            dq_out_q      <= '0;
            dq_oe_q       <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            init_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            addr_q        <= addr_d;
            write_q       <= write_d;
            gap_q         <= gap_d;
            cs_n_q        <= cs_n_d;
            dq_out_q      <= dq_out_d;
            dq_oe_q       <= dq_oe_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            init_q        <= 1'b1;
        end
    end

    assign req_ready   = w_ready;
    assign wdata_ready = w_want_wdata && wdata_valid;
    assign cs_n        = cs_n_q;
    assign dq_out      = dq_out_q;
    assign dq_oe       = dq_oe_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign done        = done_q;

endmodule
`default_nettype wire
